// File: rtl/reg_ctrl_pkg.sv
// reg_ctrl_pkg: shared types and constants for the register-bank write arbiter.
//   state_t      : arbiter FSM states
//   ACC_ADDR     : accumulator (global) register address
//   BANK_REG_ADDR: bank-select (global) register address
//   BANK0..2     : bank encodings held in the bank-select register
//   norm_bank()  : maps a requested bank onto a legal bank (3 -> 0)
package reg_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SWITCH,
        WRITE,
        RESTORE
    } state_t;

    localparam int unsigned ACC_ADDR      = 0;
    localparam int unsigned BANK_REG_ADDR = 1;

    localparam logic [1:0] BANK0 = 2'd0;
    localparam logic [1:0] BANK1 = 2'd1;
    localparam logic [1:0] BANK2 = 2'd2;

    function automatic logic [1:0] norm_bank(input logic [1:0] bank);
        return (bank == 2'd3) ? BANK0 : bank;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin picker.
//   clk, reset_n : clock, synchronous active-low reset
//   req          : per-input request
//   update       : commit the current grant as the new last-grant pointer
//   grant_idx    : index of the granted input (combinational)
//   grant_valid  : at least one input is requesting
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant_idx,
    output logic       grant_valid
);

    logic last;

    // Ties go to the input that did not win last time; reset value of 1
    // lets input 0 win the first tie.
    always_comb begin
        grant_valid = |req;
        grant_idx   = (&req) ? ~last : req[1];
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            last <= 1'b1;
        else if (update)
            last <= grant_idx;
    end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// reg_bank_write_arbiter: shares the register file's single write port
// between core writeback (port 0) and the loader/debug port (port 1),
// inserting bank-select writes to register 1 before banked writes and,
// for port 1, restoring the previous bank afterwards.
//   clk, reset_n          : clock, synchronous active-low reset
//   req_valid[1:0]        : per-port request, held until that port's ack
//   req_bankN/addrN/dataN : target bank, register and data per port
//   ack[1:0]              : one-cycle pulse when the port's data write issues
//   busy                  : FSM not in IDLE
//   cur_bank              : shadow of the bank selected in the register file
//   write_en/waddr/data_in: register-file write port
module reg_bank_write_arbiter
    import reg_ctrl_pkg::*;
#(
    parameter int unsigned DW         = 8,
    parameter int unsigned AW         = 3,
    parameter int unsigned RESTORE_P1 = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [1:0]    req_valid,
    input  logic [1:0]    req_bank0,
    input  logic [1:0]    req_bank1,
    input  logic [AW-1:0] req_addr0,
    input  logic [AW-1:0] req_addr1,
    input  logic [DW-1:0] req_data0,
    input  logic [DW-1:0] req_data1,
    output logic [1:0]    ack,
    output logic          busy,
    output logic [1:0]    cur_bank,
    output logic          write_en,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] data_in
);

    state_t        state, state_nxt;
    logic          grant_idx, grant_valid, arb_update;
    logic [1:0]    sel_bank;
    logic [AW-1:0] sel_addr;
    logic          need_switch;

    logic          lat_port, lat_switch;
    logic [1:0]    lat_bank, saved_bank;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_data;

    rr_arb2 u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req_valid),
        .update     (arb_update),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    // Globals (addr 0/1) live outside the banks and never need a switch.
    always_comb begin
        sel_bank    = norm_bank(grant_idx ? req_bank1 : req_bank0);
        sel_addr    = grant_idx ? req_addr1 : req_addr0;
        need_switch = (sel_addr > AW'(BANK_REG_ADDR)) && (sel_bank != cur_bank);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= INIT;
            cur_bank   <= BANK0;
            saved_bank <= BANK0;
            lat_port   <= 1'b0;
            lat_switch <= 1'b0;
            lat_bank   <= BANK0;
            lat_addr   <= '0;
            lat_data   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        lat_port   <= grant_idx;
                        lat_bank   <= sel_bank;
                        lat_addr   <= sel_addr;
                        lat_data   <= grant_idx ? req_data1 : req_data0;
                        lat_switch <= need_switch;
                    end
                end
                SWITCH: begin
                    saved_bank <= cur_bank;
                    cur_bank   <= lat_bank;
                end
                WRITE: begin
                    // A direct write to the bank register moves the shadow too.
                    if (lat_addr == AW'(BANK_REG_ADDR))
                        cur_bank <= (lat_data == DW'(1)) ? BANK1 :
                                    (lat_data == DW'(2)) ? BANK2 : BANK0;
                end
                RESTORE: cur_bank <= saved_bank;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        write_en   = 1'b0;
        waddr      = '0;
        data_in    = '0;
        ack        = '0;
        arb_update = 1'b0;
        case (state)
            INIT: begin
                write_en  = 1'b1;
                waddr     = AW'(BANK_REG_ADDR);
                state_nxt = IDLE;
            end
            IDLE: begin
                if (grant_valid) begin
                    arb_update = 1'b1;
                    state_nxt  = need_switch ? SWITCH : WRITE;
                end
            end
            SWITCH: begin
                write_en  = 1'b1;
                waddr     = AW'(BANK_REG_ADDR);
                data_in   = DW'(lat_bank);
                state_nxt = WRITE;
            end
            WRITE: begin
                write_en      = 1'b1;
                waddr         = lat_addr;
                data_in       = lat_data;
                ack[lat_port] = 1'b1;
                state_nxt     = (lat_port && (RESTORE_P1 != 0) && lat_switch) ? RESTORE : IDLE;
            end
            RESTORE: begin
                write_en  = 1'b1;
                waddr     = AW'(BANK_REG_ADDR);
                data_in   = DW'(saved_bank);
                state_nxt = IDLE;
            end
            default: state_nxt = INIT;
        endcase
        // State sits at INIT throughout reset; the INIT write must only
        // appear once reset_n is released, so outputs are held quiet here.
        if (!reset_n) begin
            write_en   = 1'b0;
            waddr      = '0;
            data_in    = '0;
            ack        = '0;
            arb_update = 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
module tb_reg_bank_write_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req_valid;
    logic [1:0] req_bank0, req_bank1;
    logic [2:0] req_addr0, req_addr1;
    logic [7:0] req_data0, req_data1;
    logic [1:0] ack;
    logic       busy;
    logic [1:0] cur_bank;
    logic       write_en;
    logic [2:0] waddr;
    logic [7:0] data_in;

    int n_pass  = 0;
    int n_total = 0;

    reg_bank_write_arbiter #(.DW(8), .AW(3), .RESTORE_P1(1)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_bank0(req_bank0),
        .req_bank1(req_bank1),
        .req_addr0(req_addr0),
        .req_addr1(req_addr1),
        .req_data0(req_data0),
        .req_data1(req_data1),
        .ack      (ack),
        .busy     (busy),
        .cur_bank (cur_bank),
        .write_en (write_en),
        .waddr    (waddr),
        .data_in  (data_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       p;
        logic [1:0] bank;
        logic [2:0] addr;
        logic [7:0] data;
        int         nw;
        logic [2:0] wa0, wa1, wa2;
        logic [7:0] wd0, wd1, wd2;
        int         ack_c;
        logic [1:0] cur;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic vec_t mk(input logic p, input logic [1:0] bank, input logic [2:0] addr,
                                input logic [7:0] data, input int nw,
                                input logic [2:0] wa0, input logic [7:0] wd0,
                                input logic [2:0] wa1, input logic [7:0] wd1,
                                input logic [2:0] wa2, input logic [7:0] wd2,
                                input int ack_c, input logic [1:0] cur);
        vec_t v;
        v.p = p; v.bank = bank; v.addr = addr; v.data = data; v.nw = nw;
        v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1; v.wa2 = wa2; v.wd2 = wd2;
        v.ack_c = ack_c; v.cur = cur;
        return v;
    endfunction

    // Called just after a negedge with the DUT in IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        int         nw = 0;
        int         ack_c = -1;
        int         end_c = -1;
        int         bad = 0;
        logic [2:0] ga[3];
        logic [7:0] gd[3];
        logic [2:0] ea[3];
        logic [7:0] ed[3];
        ea[0] = v.wa0; ea[1] = v.wa1; ea[2] = v.wa2;
        ed[0] = v.wd0; ed[1] = v.wd1; ed[2] = v.wd2;
        for (int i = 0; i < 3; i++) begin ga[i] = 'x; gd[i] = 'x; end
        req_valid = v.p ? 2'b10 : 2'b01;
        if (v.p) begin req_bank1 = v.bank; req_addr1 = v.addr; req_data1 = v.data; end
        else     begin req_bank0 = v.bank; req_addr0 = v.addr; req_data0 = v.data; end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (write_en) begin
                if (nw < 3) begin ga[nw] = waddr; gd[nw] = data_in; end
                nw++;
            end
            if (ack[v.p]) begin
                if (ack_c < 0) ack_c = c;
                req_valid = 2'b00;
            end
            if (v.p ? ack[0] : ack[1]) bad++;
            if (!busy) begin end_c = c; break; end
        end
        req_valid = 2'b00;
        check($sformatf("v%0d_idle_cycle", idx), end_c, v.nw);
        check($sformatf("v%0d_num_writes", idx), nw, v.nw);
        for (int i = 0; i < v.nw; i++) begin
            check($sformatf("v%0d_waddr%0d", idx, i), int'(ga[i]), int'(ea[i]));
            check($sformatf("v%0d_wdata%0d", idx, i), int'(gd[i]), int'(ed[i]));
        end
        check($sformatf("v%0d_ack_cycle", idx), ack_c, v.ack_c);
        check($sformatf("v%0d_wrong_port_ack", idx), bad, 0);
        check($sformatf("v%0d_cur_bank", idx), int'(cur_bank), int'(v.cur));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_ack;

        //           p     bank  addr  data  nw  (a0,d0)        (a1,d1)        (a2,d2)       ackc cur
        vecs[0]  = mk(1'b0, 2'd0, 3'd3, 8'h5A, 1, 3'd3, 8'h5A, 3'd0, 8'h00, 3'd0, 8'h00, 0, 2'd0);
        vecs[1]  = mk(1'b1, 2'd2, 3'd4, 8'hC3, 3, 3'd1, 8'h02, 3'd4, 8'hC3, 3'd1, 8'h00, 1, 2'd0);
        vecs[2]  = mk(1'b0, 2'd1, 3'd2, 8'h11, 2, 3'd1, 8'h01, 3'd2, 8'h11, 3'd0, 8'h00, 1, 2'd1);
        vecs[3]  = mk(1'b1, 2'd3, 3'd5, 8'h22, 3, 3'd1, 8'h00, 3'd5, 8'h22, 3'd1, 8'h01, 1, 2'd1);
        vecs[4]  = mk(1'b0, 2'd2, 3'd0, 8'hAA, 1, 3'd0, 8'hAA, 3'd0, 8'h00, 3'd0, 8'h00, 0, 2'd1);
        vecs[5]  = mk(1'b0, 2'd2, 3'd1, 8'h07, 1, 3'd1, 8'h07, 3'd0, 8'h00, 3'd0, 8'h00, 0, 2'd0);
        vecs[6]  = mk(1'b1, 2'd3, 3'd6, 8'h44, 1, 3'd6, 8'h44, 3'd0, 8'h00, 3'd0, 8'h00, 0, 2'd0);
        vecs[7]  = mk(1'b1, 2'd1, 3'd1, 8'h02, 1, 3'd1, 8'h02, 3'd0, 8'h00, 3'd0, 8'h00, 0, 2'd2);
        vecs[8]  = mk(1'b1, 2'd2, 3'd7, 8'h99, 1, 3'd7, 8'h99, 3'd0, 8'h00, 3'd0, 8'h00, 0, 2'd2);
        vecs[9]  = mk(1'b1, 2'd0, 3'd2, 8'h10, 3, 3'd1, 8'h00, 3'd2, 8'h10, 3'd1, 8'h02, 1, 2'd2);
        vecs[10] = mk(1'b0, 2'd0, 3'd1, 8'h01, 1, 3'd1, 8'h01, 3'd0, 8'h00, 3'd0, 8'h00, 0, 2'd1);
        vecs[11] = mk(1'b0, 2'd0, 3'd3, 8'h33, 2, 3'd1, 8'h00, 3'd3, 8'h33, 3'd0, 8'h00, 1, 2'd0);

        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_bank0 = '0; req_bank1 = '0;
        req_addr0 = '0; req_addr1 = '0;
        req_data0 = '0; req_data1 = '0;

        // Reset for two cycles, then the INIT bank-register write.
        repeat (2) @(negedge clk);
        check("rst_write_en", int'(write_en), 0);
        check("rst_ack", int'(ack), 0);
        check("rst_waddr", int'(waddr), 0);
        check("rst_data_in", int'(data_in), 0);
        reset_n = 1'b1;
        #1;
        check("init_write_en", int'(write_en), 1);
        check("init_waddr", int'(waddr), 1);
        check("init_data_in", int'(data_in), 0);
        @(negedge clk);
        check("post_init_busy", int'(busy), 0);
        check("post_init_cur_bank", int'(cur_bank), 0);
        check("post_init_write_en", int'(write_en), 0);

        // Both ports hold addr-0 requests: grants alternate 0,1,0,1.
        req_valid = 2'b11;
        req_bank0 = 2'd2; req_addr0 = 3'd0; req_data0 = 8'hA0;
        req_bank1 = 2'd2; req_addr1 = 3'd0; req_data1 = 8'hB1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_ack = (c % 2 == 1) ? 2'b00 : ((c % 4 == 0) ? 2'b01 : 2'b10);
            check($sformatf("rr_ack_c%0d", c), int'(ack), int'(exp_ack));
            check($sformatf("rr_write_en_c%0d", c), int'(write_en), (c % 2 == 0) ? 1 : 0);
            if (c % 2 == 0) begin
                check($sformatf("rr_waddr_c%0d", c), int'(waddr), 0);
                check($sformatf("rr_data_c%0d", c), int'(data_in), (c % 4 == 0) ? 8'hA0 : 8'hB1);
            end
        end
        req_valid = 2'b00;
        check("rr_cur_bank", int'(cur_bank), 0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset asserted while in SWITCH aborts with no ack.
        req_valid = 2'b10;
        req_bank1 = 2'd1; req_addr1 = 3'd4; req_data1 = 8'h55;
        @(negedge clk);
        check("abort_sw_write_en", int'(write_en), 1);
        check("abort_sw_waddr", int'(waddr), 1);
        check("abort_sw_data", int'(data_in), 1);
        reset_n = 1'b0;
        #1;
        check("abort_write_en_in_reset", int'(write_en), 0);
        @(negedge clk);
        check("abort_next_write_en", int'(write_en), 0);
        check("abort_next_ack", int'(ack), 0);
        req_valid = 2'b00;
        reset_n   = 1'b1;
        #1;
        check("abort_init_write_en", int'(write_en), 1);
        check("abort_init_waddr", int'(waddr), 1);
        check("abort_init_data", int'(data_in), 0);
        check("abort_init_ack", int'(ack), 0);
        @(negedge clk);
        check("abort_idle_busy", int'(busy), 0);
        check("abort_cur_bank", int'(cur_bank), 0);
        check("abort_idle_ack", int'(ack), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_bank_write_arbiter.md
Name: reg_bank_write_arbiter

Overview:
- Shares the register file's single write port between two requesters:
  - port 0 is core writeback;
  - port 1 is the background loader/debug port.
- Each request names a target bank and register.
- The block sequences the bank-select write (r1) before the data write when needed. For port 1 it restores the previous bank afterwards, so the bank switch is invisible to the core.
- Sits between the requesters and the register file's write_en/waddr/data_in pins; it is the only driver of those pins.

Parameters:
- DW, 8, data width.
- AW, 3, register address width.
- RESTORE_P1, 1, when 1, port 1 transactions that switched bank restore the original bank afterwards.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous reset, active-low.
- req_valid  in  2  per-port request; held until that port's ack.
- req_bank0 / req_bank1  in  2 each  target bank (0, 1, 2; 3 is treated as 0).
- req_addr0 / req_addr1  in  AW each  target register.
- req_data0 / req_data1  in  DW each  write data.
- ack  out  2  one-cycle pulse per port in the cycle its data write is issued.
- busy  out  1  high whenever state is not IDLE.
- cur_bank  out  2  shadow of the bank currently selected in the register file.
- write_en  out  1  register-file write enable.
- waddr  out  AW  register-file write address.
- data_in  out  DW  register-file write data.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. While reset_n=0: state=INIT, cur_bank=0, rr_last=1 (port 0 wins the first tie), ack=0, write_en=0, waddr=0, data_in=0.
- Reset asserted mid-transaction aborts it with no ack. The requester must keep or reissue its request.
- Outputs are decoded from registered state plus latched request fields; there is no combinational path from req_* to write_en/waddr/data_in.
- States: INIT, IDLE, SWITCH, WRITE, RESTORE.
- INIT (first cycle after reset release): write_en=1, waddr=1, data_in=0. Next state IDLE. This initialises the register file's bank register, which has no reset of its own.
- IDLE:
  - If any req_valid, choose a winner round-robin: with both valid, grant the port not equal to rr_last.
  - Latch the winner's bank/addr/data and update rr_last.
  - Set need_switch = (addr>=2) && (norm(bank) != cur_bank). Next state is SWITCH if need_switch, else WRITE.
  - No writes are issued in IDLE.
- SWITCH: write_en=1, waddr=1, data_in=norm(bank). Save the old cur_bank into saved_bank, set cur_bank=norm(bank). Next state WRITE.
- WRITE: write_en=1, waddr=addr, data_in=data, ack[winner]=1.
  - If addr==1, set cur_bank = (data==1)?1:(data==2)?2:0.
  - Next state is RESTORE if winner==1 && RESTORE_P1 && a switch occurred; otherwise IDLE.
- RESTORE: write_en=1, waddr=1, data_in=saved_bank, cur_bank=saved_bank. Next state IDLE.
- Latency, request seen in IDLE at cycle N:
  - data write at N+1 without a switch, N+2 with a switch;
  - back in IDLE at N+2, N+3, or N+4 (with restore).
- Global registers (addr 0 and 1) never trigger a switch, whatever req_bank says.
- A request that deasserts before its ack is still completed once latched. Requesters must not do this; the behaviour is defined only for robustness.
- A port may re-request in the cycle after its ack; round-robin then favours the other port if it is valid.
- Throughput: at most one transaction per two cycles.

Decomposition:
- Package reg_ctrl_pkg holds:
  - state_t enum {INIT, IDLE, SWITCH, WRITE, RESTORE};
  - localparams ACC_ADDR=0, BANK_REG_ADDR=1;
  - bank constants BANK0=0, BANK1=1, BANK2=2;
  - norm_bank() function.
- One sub-module, rr_arb2: two-input round-robin picker, combinational grant with registered last-grant pointer and an update enable.

Test Plan:
- Reset then idle: hold reset_n=0 for 2 cycles, then release → INIT cycle shows write_en=1, waddr=1, data_in=0; then busy=0 and cur_bank=0.
- No switch needed: port 0 requests bank 0, addr 3, data 8'h5A at cycle N → write_en=1, waddr=3, data_in=8'h5A at N+1; ack[0] at N+1; cur_bank stays 0.
- Switch with restore: cur_bank=0; port 1 requests bank 2, addr 4, data 8'hC3 → writes (1,2), then (4,8'hC3) with ack[1], then (1,0); cur_bank ends at 0.
- Port 0 switch persists: port 0 requests bank 1, addr 2, data 8'h11 → writes (1,1), then (2,8'h11); no restore; cur_bank=1.
- Both ports valid continuously, each requesting addr 0 → grants alternate 0,1,0,1; no SWITCH states; one ack every 2 cycles.
- Corner cases:
  - Port 0 writes addr 1, data 8'h07 → cur_bank=0.
  - Port 1 with bank 3 while cur_bank=0 → no switch.
  - reset_n low during SWITCH → no ack, write_en=0 next cycle, INIT follows release.
